pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
Parametrised elastic pipeline register for the stage boundaries of the pipelined core (F/D, D/E, E/M, M/W). It replaces the hard-wired enable/clear stage register with a valid/ready handshake. A 2-entry skid buffer keeps in_ready registered, and a synchronous flush kills in-flight instructions. Saturating stall and flush counters are included for performance debug.

Parameters:
DATA_W, 96, width of the payload bundle (e.g. {Instr, PC, PCPlus4} = 3x32).
CNT_W, 16, width of each saturating event counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
flush  input  1  synchronous kill of all held entries (branch mispredict / exception).
cnt_clr  input  1  synchronous clear of both event counters.
in_valid  input  1  upstream holds a valid payload.
in_ready  output  1  stage can accept; driven directly from a register.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  main register holds a valid payload.
out_ready  input  1  downstream accepts this cycle.
out_data  output  DATA_W  main register payload.
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
flush_cnt  output  CNT_W  flushes that killed at least one valid entry.

Behaviour:
- Reset (async) values:
  - state=EMPTY, in_ready=1, out_valid=0.
  - out_data=0, skid register=0.
  - stall_cnt=0, flush_cnt=0.
- Transfer definitions:
  - in-transfer = in_valid & in_ready & ~flush.
  - out-transfer = out_valid & out_ready.
- Latency: payload accepted in cycle N appears on out_data with out_valid=1 in cycle N+1. Sustained throughput is 1 per cycle while out_ready=1.
- States; out_valid = (state != EMPTY), in_ready = (state != SKID):
  - EMPTY:
    - in-transfer -> main<=in_data, go FULL.
  - FULL:
    - in-transfer and out_ready -> main<=in_data, stay FULL.
    - in-transfer and ~out_ready -> skid<=in_data, go SKID; main is unchanged.
    - no in-transfer and out_ready -> go EMPTY.
    - otherwise hold.
  - SKID:
    - out_ready -> main<=skid, go FULL. No input is accepted this cycle since in_ready=0.
    - otherwise hold both entries.
- Ordering: payloads leave strictly in acceptance order; none dropped or duplicated except by flush.
- Flush (highest priority, synchronous):
  - Next state is EMPTY from any state.
  - main<=0 and skid<=0, giving a NOP-equivalent all-zero payload.
  - in_valid in the same cycle is not accepted; the upstream stage is flushed by the same signal.
  - out-transfer in the flush cycle still counts as completed downstream.
- Data registers load only on the transitions listed; otherwise they hold their value.
- stall_cnt: +1 each cycle with out_valid & ~out_ready; saturates at 2^CNT_W-1.
- flush_cnt: +1 on flush when state != EMPTY; saturates at 2^CNT_W-1.
- cnt_clr: both counters <=0, overriding any increment in the same cycle; no effect on the pipeline.
- Reset asserted mid-operation: immediate return to reset values; held payloads are lost.

Test Plan:
1. Streaming: out_ready=1; in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each, out_valid=1 for 4 cycles, stall_cnt=0.
2. Backpressure/skid: state FULL holding 0xA; send 0xB with out_ready=0 -> in_ready=0 next cycle, out_data holds 0xA. Raise out_ready -> sequence 0xA, 0xB. stall_cnt equals the number of out_ready=0 cycles.
3. Flush in SKID state -> next cycle out_valid=0, out_data=0, in_ready=1, flush_cnt=1. Flush again while EMPTY -> flush_cnt stays 1.
4. Flush with simultaneous in_valid=1, in_data=0x55 -> 0x55 never appears on out_data.
5. Saturation: CNT_W=4; out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt=15. Pulse cnt_clr -> 0.
6. Async rst pulse between clock edges while FULL -> out_valid=0, out_data=0, in_ready=1 immediately, before the next edge.

Source files
------------

// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for one elastic stage boundary: upstream side, downstream side,
// kill/clear controls and the debug event counters.
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 96,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              cnt_clr;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output flush, cnt_clr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, stall_cnt, flush_cnt
    );

    modport slave (
        input  flush, cnt_clr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer: in_ready and out_valid are
// registered, flush zeroes both entries, and saturating stall/flush counters aid debug.
module pipe_stage_elastic #(
    parameter int DATA_W = 96,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_elastic_if.slave  io_bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_in_xfer;
    logic w_ld_main_in;
    logic w_ld_main_skid;
    logic w_ld_skid;
    logic w_clr_data;
    logic w_stall_evt;
    logic w_flush_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_in_xfer   = io_bus.in_valid & r_in_ready & ~io_bus.flush;
    assign w_stall_evt = r_out_valid & ~io_bus.out_ready;
    assign w_flush_evt = io_bus.flush & (r_state != ST_EMPTY);

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        w_clr_data     = 1'b0;
        if (io_bus.flush) begin
            w_state_nxt = ST_EMPTY;
            w_clr_data  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_ld_main_in = 1'b1;
                        w_state_nxt  = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_in_xfer && io_bus.out_ready) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_in_xfer) begin
                        // Downstream stalled: park the new payload, main keeps the older one.
                        w_ld_skid   = 1'b1;
                        w_state_nxt = ST_SKID;
                    end else if (io_bus.out_ready) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (io_bus.out_ready) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = ST_FULL;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_SKID);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_clr_data) begin
                r_main <= '0;
                r_skid <= '0;
            end else begin
                if (w_ld_main_in)
                    r_main <= io_bus.in_data;
                else if (w_ld_main_skid)
                    r_main <= r_skid;
                if (w_ld_skid)
                    r_skid <= io_bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (io_bus.cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt)
                r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_flush_evt)
                r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_main;
    assign io_bus.stall_cnt = r_stall_cnt;
    assign io_bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: streaming, skid backpressure, flush,
// counter saturation with a 4-bit counter, and asynchronous reset.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 96;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    pipe_stage_elastic_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    pipe_stage_elastic #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk          = 0;
        n_pass         = 0;
        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.cnt_clr    = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;

        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        chk("rst_flush_cnt", bus.flush_cnt, 0);
        #10 rst = 1'b0;
        tick();

        // Streaming 1..4 with out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(i);
            tick();
            chk("stream_valid", bus.out_valid, 1);
            chk("stream_data",  bus.out_data,  i);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", bus.out_valid, 0);
        chk("stream_stall_cnt",   bus.stall_cnt, 0);

        // Backpressure into the skid entry
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 'hA;
        tick();
        chk("bp_load_data",  bus.out_data, 'hA);
        chk("bp_load_ready", bus.in_ready, 1);
        bus.in_data = 'hB;
        tick();
        chk("bp_skid_ready", bus.in_ready,  0);
        chk("bp_skid_data",  bus.out_data,  'hA);
        chk("bp_skid_stall", bus.stall_cnt, 1);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_hold_data",  bus.out_data,  'hA);
        chk("bp_hold_stall", bus.stall_cnt, 2);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_second_data",  bus.out_data,  'hB);
        chk("bp_second_valid", bus.out_valid, 1);
        chk("bp_second_ready", bus.in_ready,  1);
        tick();
        chk("bp_empty_valid", bus.out_valid, 0);
        chk("bp_final_stall", bus.stall_cnt, 2);

        // Flush while in SKID, then flush again while EMPTY
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 'h11;
        tick();
        bus.in_data = 'h22;
        tick();
        chk("fl_pre_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        tick();
        chk("fl_skid_valid", bus.out_valid, 0);
        chk("fl_skid_data",  bus.out_data,  0);
        chk("fl_skid_ready", bus.in_ready,  1);
        chk("fl_skid_cnt",   bus.flush_cnt, 1);
        tick();
        chk("fl_empty_cnt",  bus.flush_cnt, 1);
        bus.flush = 1'b0;

        // Flush with a simultaneous input: 0x55 must never be taken
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 'h33;
        tick();
        chk("fl_in_pre_data", bus.out_data, 'h33);
        bus.in_data = 'h55;
        bus.flush   = 1'b1;
        tick();
        chk("fl_in_valid", bus.out_valid, 0);
        chk("fl_in_data",  bus.out_data,  0);
        chk("fl_in_cnt",   bus.flush_cnt, 2);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("fl_in_after_valid", bus.out_valid, 0);
        chk("fl_in_after_data",  bus.out_data,  0);

        // Counter clear and stall saturation at 15
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        chk("clr_stall", bus.stall_cnt, 0);
        chk("clr_flush", bus.flush_cnt, 0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 'h77;
        tick();
        bus.in_valid = 1'b0;
        chk("sat_start", bus.stall_cnt, 0);
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", bus.stall_cnt, 14);
        tick();
        chk("sat_15", bus.stall_cnt, 15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", bus.stall_cnt, 15);
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        chk("sat_clr",       bus.stall_cnt, 0);
        chk("sat_clr_data",  bus.out_data,  'h77);
        chk("sat_clr_valid", bus.out_valid, 1);
        tick();
        chk("sat_restart", bus.stall_cnt, 1);

        // Asynchronous reset between edges while FULL
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_data",  bus.out_data,  0);
        chk("arst_ready", bus.in_ready,  1);
        chk("arst_stall", bus.stall_cnt, 0);
        #2 rst = 1'b0;
        tick();
        chk("arst_after_valid", bus.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
